// File: rtl/cordic_share_arbiter.sv
// Round-robin arbiter that time-shares one CORDIC linear-mode divider (z = y/x) among NREQ requesters.
// Optional watchdog on the core handshake is compiled in with `define CORDIC_TIMEOUT_EN.
module cordic_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_x,
    input  logic [NREQ*DW-1:0]   req_y,
    output logic                 core_start,
    output logic [DW-1:0]        core_x,
    output logic [DW-1:0]        core_y,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_z,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic [IDW-1:0]  id_reg, id_next;
    logic [DW-1:0]   x_reg, x_next;
    logic [DW-1:0]   y_reg, y_next;
    logic [DW-1:0]   data_reg, data_next;
    logic            err_reg, err_next;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;

`ifdef CORDIC_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]  wd_reg, wd_next;
    logic            wd_expired;

    // Expires on the TIMEOUT-th WAIT cycle so RESP follows exactly TIMEOUT WAIT cycles.
    assign wd_expired = (wd_reg == WDW'(TIMEOUT - 1));
`endif

    // (base + k) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[IDW-1:0];
    endfunction

    // Search from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_inc(ptr_reg, k)]) begin
                grant_idx = wrap_inc(ptr_reg, k);
            end
        end
    end

    assign grant_valid = (state_reg == IDLE) && (|req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
`ifdef CORDIC_TIMEOUT_EN
            wd_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
`ifdef CORDIC_TIMEOUT_EN
            wd_reg    <= wd_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        data_next  = data_reg;
        err_next   = err_reg;
`ifdef CORDIC_TIMEOUT_EN
        wd_next    = wd_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    x_next     = req_x[int'(grant_idx) * DW +: DW];
                    y_next     = req_y[int'(grant_idx) * DW +: DW];
                    id_next    = grant_idx;
                    ptr_next   = wrap_inc(grant_idx, 1);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
`ifdef CORDIC_TIMEOUT_EN
                wd_next    = '0;
`endif
                state_next = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    data_next  = core_z;
                    err_next   = 1'b0;
                    state_next = RESP;
`ifdef CORDIC_TIMEOUT_EN
                end else if (wd_expired) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    wd_next    = wd_reg + WDW'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // All handshake outputs decode the state register, so reset clears them at once.
    always_comb begin
        core_start = (state_reg == ISSUE);
        rsp_valid  = (state_reg == RESP);
        busy       = (state_reg != IDLE);
        core_x     = x_reg;
        core_y     = y_reg;
        rsp_id     = id_reg;
        rsp_data   = data_reg;
`ifdef CORDIC_TIMEOUT_EN
        rsp_err    = err_reg;
`else
        rsp_err    = 1'b0;
`endif
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_valid && (grant_idx == IDW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed plus randomized bench for cordic_share_arbiter with a latency-programmable core model.
module tb_cordic_share_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_x;
    logic [NREQ*DW-1:0]  req_y;
    logic                core_start;
    logic [DW-1:0]       core_x;
    logic [DW-1:0]       core_y;
    logic                core_done;
    logic [DW-1:0]       core_z;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic                busy;

    cordic_share_arbiter #(
        .NREQ(NREQ), .DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_z(core_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    int mptr   = 0;
    int start_cnt = 0;

    // Core model: done pulses core_lat cycles after the start pulse is seen.
    int          core_lat = 5;
    bit          core_never = 1'b0;
    int          core_cnt = 0;
    bit          core_pend = 1'b0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [31:0] model_z = '0;
    logic [31:0] next_z = '0;

    assign core_done = model_done | spur_done;
    assign core_z    = model_z;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) begin
            core_pend = 1'b0;
        end else begin
            if (core_pend) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) begin
                    model_done = 1'b1;
                    model_z    = next_z;
                    core_pend  = 1'b0;
                end
            end
            if (core_start === 1'b1 && !core_never) begin
                core_pend = 1'b1;
                core_cnt  = core_lat;
            end
        end
    end

    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt = start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish within bound");
        $fatal(1, "simulation time limit exceeded");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first valid requester at or after the model pointer.
    function automatic int exp_winner(input logic [NREQ-1:0] pat);
        for (int k = 0; k < NREQ; k++) begin
            if (pat[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [NREQ-1:0] pat, input bit keep, input int lat,
                           input int bp, input bit spur_issue, input bit expect_to);
        int w, n, sc0, exp_n;
        logic [31:0] ex, ey, ez;
        core_lat   = lat;
        core_never = expect_to;
        ez         = $urandom;
        next_z     = ez;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*DW +: DW] = $urandom;
            req_y[i*DW +: DW] = $urandom;
        end
        req_valid = pat;
        w  = exp_winner(pat);
        ex = req_x[w*DW +: DW];
        ey = req_y[w*DW +: DW];
        sc0 = start_cnt;
        #1;
        check("req_ready_grant", 32'(req_ready), 32'(1 << w));
        @(negedge clk);
        if (!keep) req_valid = '0;
        mptr = (w + 1) % NREQ;
        check("core_start_issue", 32'(core_start), 32'd1);
        check("core_x", core_x, ex);
        check("core_y", core_y, ey);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (spur_issue) spur_done = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            spur_done = 1'b0;
            n++;
        end
        exp_n = expect_to ? TIMEOUT + 1 : lat + 1;
        check("rsp_latency", 32'(n), 32'(exp_n));
        check("rsp_id", 32'(rsp_id), 32'(w));
        check("rsp_data", rsp_data, expect_to ? 32'd0 : ez);
        check("rsp_err", 32'(rsp_err), 32'(expect_to));
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_id", 32'(rsp_id), 32'(w));
            check("bp_data", rsp_data, expect_to ? 32'd0 : ez);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("start_pulses", 32'(start_cnt - sc0), 32'd1);
        $display("txn %0d: pat=%b grant=%0d lat=%0d bp=%0d id=%0d data=%h err=%0d",
                 txn_no, pat, w, n, bp, rsp_id, rsp_data, rsp_err);
        txn_no++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_core_x", core_x, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All four requesting continuously: grants rotate 0,1,2,3,0.
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, 1'b1, 4, 0, 1'b0, 1'b0);
            check("rr_order", 32'(rsp_id), 32'(t % NREQ));
        end

        // Single request from requester 1 with the nominal operands.
        core_lat   = 20;
        core_never = 1'b0;
        next_z     = 32'h3F00_0000;
        req_x[1*DW +: DW] = 32'h4000_0000;
        req_y[1*DW +: DW] = 32'h3F80_0000;
        req_valid  = 4'b0010;
        #1;
        check("single_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        mptr = 2;
        check("single_x", core_x, 32'h4000_0000);
        check("single_y", core_y, 32'h3F80_0000);
        repeat (21) @(negedge clk);
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_data", rsp_data, 32'h3F00_0000);
        check("single_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        $display("txn %0d: single request id=1 data=3f000000", txn_no);
        txn_no++;

        // Ten cycles of backpressure with other requesters waiting.
        run_txn(4'b1011, 1'b1, 6, 10, 1'b0, 1'b0);

        // Spurious done in IDLE, then again during ISSUE.
        req_valid = '0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("spur_idle_busy", 32'(busy), 32'd0);
        check("spur_idle_valid", 32'(rsp_valid), 32'd0);
        run_txn(4'b0100, 1'b0, 8, 0, 1'b1, 1'b0);

        repeat (20) begin
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 12), $urandom_range(0, 3), 1'b0, 1'b0);
        end

        // Reset in the middle of WAIT aborts the transaction.
        core_lat  = 30;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(core_start), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_core_x", core_x, 32'd0);
        check("mid_rst_core_y", core_y, 32'd0);
        mptr = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        run_txn(4'b0100, 1'b0, 5, 0, 1'b0, 1'b0);
        run_txn(4'b0011, 1'b0, 3, 1, 1'b0, 1'b0);

`ifdef CORDIC_TIMEOUT_EN
        run_txn(4'b0001, 1'b0, 5, 0, 1'b0, 1'b1);
        run_txn(4'b0001, 1'b0, 7, 0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
